// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared fetch-stage types, reset constants and word alignment.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR_C = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_pc_sel.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_sel
// Description : Next-PC priority mux: redirect target, then hold, then PC+4.
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_sel
   import mips_pkg::*;
(
   input  logic        i_redirect,
   input  logic        i_hold,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_target,
   output logic [31:0] o_next_pc,
   output logic [31:0] o_pc_plus4
);

   logic [31:0] w_pc_plus4;

   // Wraps modulo 2^32 by construction of the 32-bit add.
   assign w_pc_plus4 = i_pc + 32'd4;
   assign o_pc_plus4 = w_pc_plus4;

   always_comb begin
      o_next_pc = w_pc_plus4;
      if (i_redirect) begin
         o_next_pc = align_word(i_target);
      end else if (i_hold) begin
         o_next_pc = i_pc;
      end
   end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : IF stage: PC register, imem handshake, one-entry hold buffer
//               and IF/ID write control. IF_PERF_CNT_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_C,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_taken,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] PC4,
   output logic [31:0] Instruction,
   output logic        IF_flush,
   output logic        IF_ID_write_en
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_count
`endif
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  r_buf;
   logic [31:0]  r_drop_addr;
   logic [31:0]  w_target;
   logic [31:0]  w_next_pc;
   logic [31:0]  w_pc_plus4;
   logic         w_redirect;
   logic         w_hold;
   logic         w_buf_load;
   logic         w_drop_load;

   assign w_redirect = branch_taken | jump_taken;
   assign w_target   = branch_taken ? branch_target : jump_target;

   if_pc_sel u_pc_sel (
      .i_redirect (w_redirect),
      .i_hold     (w_hold),
      .i_pc       (r_pc),
      .i_target   (w_target),
      .o_next_pc  (w_next_pc),
      .o_pc_plus4 (w_pc_plus4)
   );

   // A dropped request must keep presenting its original address until acked.
   assign imem_addr = (r_state == DROP) ? r_drop_addr : r_pc;
   assign PC4       = rst ? (RESET_PC + 32'd4) : w_pc_plus4;

   always_comb begin
      w_state_nxt    = r_state;
      imem_req       = 1'b0;
      IF_ID_write_en = 1'b0;
      IF_flush       = 1'b0;
      Instruction    = NOP_INSTR;
      w_hold         = 1'b1;
      w_buf_load     = 1'b0;
      w_drop_load    = 1'b0;
      if (!rst) begin
         case (r_state)
            FETCH: begin
               imem_req = 1'b1;
               if (w_redirect) begin
                  IF_ID_write_en = 1'b1;
                  IF_flush       = 1'b1;
                  if (!imem_ready) begin
                     w_state_nxt = DROP;
                     w_drop_load = 1'b1;
                  end
               end else if (imem_ready) begin
                  if (!stall_in) begin
                     Instruction    = imem_rdata;
                     IF_ID_write_en = 1'b1;
                     w_hold         = 1'b0;
                  end else begin
                     w_buf_load  = 1'b1;
                     w_state_nxt = HOLD;
                  end
               end else begin
                  IF_ID_write_en = ~stall_in;
                  IF_flush       = 1'b1;
               end
            end
            HOLD: begin
               Instruction = r_buf;
               if (w_redirect) begin
                  IF_ID_write_en = 1'b1;
                  IF_flush       = 1'b1;
                  Instruction    = NOP_INSTR;
                  w_state_nxt    = FETCH;
               end else if (!stall_in) begin
                  IF_ID_write_en = 1'b1;
                  w_hold         = 1'b0;
                  w_state_nxt    = FETCH;
               end
            end
            DROP: begin
               imem_req       = 1'b1;
               IF_ID_write_en = w_redirect | ~stall_in;
               IF_flush       = 1'b1;
               if (imem_ready) begin
                  w_state_nxt = FETCH;
               end
            end
            default: begin
               w_state_nxt = FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= FETCH;
         r_pc        <= RESET_PC;
         r_buf       <= NOP_INSTR;
         r_drop_addr <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_next_pc;
         if (w_buf_load) begin
            r_buf <= imem_rdata;
         end
         if (w_drop_load) begin
            r_drop_addr <= r_pc;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_stall <= 32'd0;
         r_perf_flush <= 32'd0;
      end else begin
         if (!IF_ID_write_en && (r_perf_stall != 32'hFFFF_FFFF)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if (w_redirect && (r_perf_flush != 32'hFFFF_FFFF)) begin
            r_perf_flush <= r_perf_flush + 32'd1;
         end
      end
   end

   assign perf_stall_cycles = r_perf_stall;
   assign perf_flush_count  = r_perf_flush;
`endif

endmodule
`default_nettype wire
